// File: rtl/sseg_scroll_ctrl.sv
// sseg_scroll_ctrl
//   Message scroller for the 4-digit seven-segment display multiplexer.
//   A message of segment patterns is accepted over a valid/ready stream and
//   stored. A 4-digit window then slides across it, one position every
//   TICK_DIV clocks while `run` is high. After the message come four BLANK
//   positions, so the text scrolls fully off the display before it wraps.
//
// Parameters
//   B        segment pattern width (matches the display mux)
//   DEPTH    maximum message length in symbols (>= 4, power of two)
//   TICK_DIV clk cycles per scroll step (>= 2)
//   BLANK    pattern for an empty digit (all segments off, active-low)
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   clear                 synchronous abort back to IDLE; discards the message
//   in_valid/in_ready     message stream handshake
//   in_data/in_last       segment pattern / final symbol of the message
//   run                   1 = scroll, 0 = freeze the window
//   dig3..dig0            leftmost..rightmost digit, to mux in3..in0
//   busy                  controller is not IDLE
//   done                  one-cycle pulse at the end of a one-shot pass
//
// Build option
//   SSEG_SCROLL_ONESHOT_EN  when defined, a step taken from the last window
//                           position returns to IDLE and pulses `done`
//                           instead of wrapping; otherwise `done` is tied 0.

module sseg_scroll_ctrl #(
    parameter int unsigned  B        = 8,
    parameter int unsigned  DEPTH    = 16,
    parameter int unsigned  TICK_DIV = 50_000_000,
    parameter logic [B-1:0] BLANK    = {B{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [B-1:0] in_data,
    input  logic         in_last,
    input  logic         run,
    output logic [B-1:0] dig3,
    output logic [B-1:0] dig2,
    output logic [B-1:0] dig1,
    output logic [B-1:0] dig0,
    output logic         busy,
    output logic         done
);

    localparam int unsigned IW = $clog2(DEPTH + 4);   // window index / length width
    localparam int unsigned AW = $clog2(DEPTH);       // buffer address width
    localparam int unsigned CW = $clog2(TICK_DIV);    // tick counter width

    typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

    state_t        state_q, state_d;

    logic [B-1:0]  mem [DEPTH];
    logic [IW-1:0] count_q;   // next write index while loading
    logic [IW-1:0] len_q;     // message length L
    logic [IW-1:0] p_q;       // window start position
    logic [CW-1:0] cnt_q;     // scroll tick counter

    logic          accept;
    logic          at_top;
    logic          at_end;
    logic          tick;
    logic [AW-1:0] waddr;
    logic [IW:0]   span;
    logic [IW:0]   idx [4];
    logic [B-1:0]  win [4];

    assign accept = in_valid && in_ready;
    assign at_top = (count_q == IW'(DEPTH - 1));
    assign at_end = (p_q == len_q + IW'(3));
    assign tick   = (state_q == SCROLL) && run && (cnt_q == CW'(TICK_DIV - 1));
    assign waddr  = (state_q == IDLE) ? '0 : count_q[AW-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = in_last ? SCROLL : LOAD;
                LOAD:    if (accept && (in_last || at_top)) state_d = SCROLL;
                SCROLL: begin
`ifdef SSEG_SCROLL_ONESHOT_EN
                    if (tick && at_end) state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q != SCROLL);
        busy     = (state_q != IDLE);
    end

    // ---------------- message buffer ----------------
    always_ff @(posedge clk) begin
        if (accept && !clear) mem[waddr] <= in_data;
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            len_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            count_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    p_q   <= '0;
                    cnt_q <= '0;
                    if (accept) begin
                        count_q <= IW'(1);
                        len_q   <= IW'(1);
                    end
                end
                LOAD: begin
                    p_q   <= '0;
                    cnt_q <= '0;
                    // len tracks count+1 on every beat, so it is correct
                    // whichever beat turns out to be the last one
                    if (accept) begin
                        count_q <= count_q + IW'(1);
                        len_q   <= count_q + IW'(1);
                    end
                end
                SCROLL: begin
                    if (run) begin
                        if (tick) begin
                            cnt_q <= '0;
                            p_q   <= at_end ? '0 : p_q + IW'(1);
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    p_q   <= '0;
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // ---------------- window selection ----------------
    // p+k never reaches 2*(L+4), so one conditional subtract implements the
    // modulo; positions at or beyond L read as BLANK.
    assign span = {1'b0, len_q} + (IW+1)'(4);

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            idx[k] = {1'b0, p_q} + (IW+1)'(k);
            if (idx[k] >= span) idx[k] = idx[k] - span;
            win[k] = (idx[k] < {1'b0, len_q}) ? mem[idx[k][AW-1:0]] : BLANK;
        end
    end

    // ---------------- registered digits ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig3 <= BLANK;
            dig2 <= BLANK;
            dig1 <= BLANK;
            dig0 <= BLANK;
        end else if (state_q == SCROLL) begin
            dig3 <= win[0];
            dig2 <= win[1];
            dig1 <= win[2];
            dig0 <= win[3];
        end else begin
            dig3 <= BLANK;
            dig2 <= BLANK;
            dig1 <= BLANK;
            dig0 <= BLANK;
        end
    end

    // ---------------- end-of-pass pulse ----------------
`ifdef SSEG_SCROLL_ONESHOT_EN
    logic done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= !clear && tick && at_end;
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_scroll_ctrl.sv
// Testbench for sseg_scroll_ctrl (B=8, DEPTH=16, TICK_DIV=4, BLANK=FF).
// The reference model keeps the received message in a queue and derives the
// expected window from the number of clock edges spent scrolling with run=1:
// window position = (run_edges / TICK_DIV) mod (L+4).

module tb_sseg_scroll_ctrl;

    localparam int unsigned TD     = 4;
    localparam int unsigned DEPTH  = 16;
    localparam logic [31:0] BLANK4 = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       run;
    logic [7:0] dig3, dig2, dig1, dig0;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [7:0]  msg[$];     // message the model believes is stored
    logic [7:0]  tx[$];      // message to transmit
    bit          mdl_scroll = 0;
    int unsigned rc = 0;     // scroll edges with run=1 since SCROLL entry
    int          acc;
    int          dn;

    sseg_scroll_ctrl #(
        .B        (8),
        .DEPTH    (DEPTH),
        .TICK_DIV (TD),
        .BLANK    (8'hFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .run      (run),
        .dig3     (dig3),
        .dig2     (dig2),
        .dig1     (dig1),
        .dig0     (dig0),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] digs();
        return {dig3, dig2, dig1, dig0};
    endfunction

    function automatic logic [31:0] win(input int unsigned p);
        logic [31:0] r = '0;
        int unsigned len = msg.size();
        for (int unsigned k = 0; k < 4; k++) begin
            int unsigned i = (p + k) % (len + 4);
            r = {r[23:0], (i < len) ? msg[i] : 8'hFF};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample run at the edge, check outputs 1 time unit later.
    task automatic cyc();
        logic        r;
        logic        exp_done;
        int unsigned len;
        int unsigned steps;
        bit          ended;
        @(posedge clk);
        r = run;
        #1;
        exp_done = 1'b0;
        if (mdl_scroll) begin
            len   = msg.size();
            steps = rc / TD;
            ended = 0;
`ifdef SSEG_SCROLL_ONESHOT_EN
            ended    = (steps >= len + 4);
            exp_done = !ended && r && (rc + 1 == TD * (len + 4));
`endif
            if (ended) begin
                chk("oneshot_blank", digs(), BLANK4);
                mdl_scroll = 0;
            end else begin
                chk("window", digs(), win(steps % (len + 4)));
                if (r) rc++;
            end
        end
        chk("done", {31'b0, done}, {31'b0, exp_done});
    endtask

    task automatic runc(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load_tx(input bit bubbles);
        for (int i = 0; i < tx.size(); i++) begin
            if (bubbles) begin
                int unsigned g = $urandom_range(0, 2);
                for (int unsigned j = 0; j < g; j++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                    cyc();
                end
            end
            in_valid = 1'b1;
            in_data  = tx[i];
            in_last  = (i == tx.size() - 1);
            chk("ready_load", {31'b0, in_ready}, 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        msg = tx;
        mdl_scroll = 1;
        rc = 0;
        chk("busy_scroll", {31'b0, busy}, 32'd1);
        chk("ready_scroll", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        mdl_scroll = 0;
        cyc();
        clear = 1'b0;
        chk("clear_busy", {31'b0, busy}, 32'd0);
        chk("clear_ready", {31'b0, in_ready}, 32'd1);
        cyc();
        chk("clear_blank", digs(), BLANK4);
    endtask

    task automatic rand_tx(input int n);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; run = 1'b1;
        #1;
        chk("rst_digits", digs(), BLANK4);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // five-symbol message, directed window checks
        tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load_tx(0);
        cyc();
        chk("A_w0", digs(), 32'h01020304);
        runc(4);
        chk("A_w1", digs(), 32'h02030405);
        runc(8);
        chk("A_w3", digs(), 32'h0405FFFF);
        runc(24);
`ifdef SSEG_SCROLL_ONESHOT_EN
        chk("A_end", digs(), BLANK4);
        chk("A_end_busy", {31'b0, busy}, 32'd0);
`else
        chk("A_wrap", digs(), 32'h01020304);
`endif
        do_clear();

        // asynchronous reset in the middle of scrolling
        rand_tx(6);
        load_tx(1);
        runc(7);
        #2 rst = 1'b1;
        mdl_scroll = 0;
        #1;
        chk("arst_digits", digs(), BLANK4);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_ready", {31'b0, in_ready}, 32'd1);
        #1 rst = 1'b0;
        cyc();
        chk("arst_after", digs(), BLANK4);

        // 20 beats without in_last: only DEPTH are accepted
        rand_tx(20);
        acc = 0;
        for (int b = 0; b < 20; b++) begin
            in_valid = 1'b1;
            in_data  = tx[b];
            in_last  = 1'b0;
            chk("ready_20", {31'b0, in_ready}, (b < 16) ? 32'd1 : 32'd0);
            if (in_ready) acc++;
            cyc();
            if (b == 15) begin
                msg.delete();
                for (int i = 0; i < 16; i++) msg.push_back(tx[i]);
                mdl_scroll = 1;
                rc = 0;
            end
        end
        in_valid = 1'b0;
        chk("accepted", acc, 32'd16);
        runc(77);
`ifdef SSEG_SCROLL_ONESHOT_EN
        chk("L16_end", digs(), BLANK4);
`else
        chk("L16_period", digs(), {tx[0], tx[1], tx[2], tx[3]});
`endif
        do_clear();

        // single-symbol message
        tx = '{8'hC0};
        load_tx(0);
        cyc();
        chk("L1_w0", digs(), 32'hC0FFFFFF);
        runc(8);
        chk("L1_w2", digs(), 32'hFFFFFFC0);
        runc(12);
`ifdef SSEG_SCROLL_ONESHOT_EN
        chk("L1_end", digs(), BLANK4);
`else
        chk("L1_wrap", digs(), 32'hC0FFFFFF);
`endif
        do_clear();

        // freeze with run low at cnt=2
        tx = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_tx(0);
        runc(2);
        run = 1'b0;
        runc(10);
        chk("frz_hold", digs(), 32'h11223344);
        run = 1'b1;
        runc(2);
        chk("frz_pre", digs(), 32'h11223344);
        cyc();
        chk("frz_step", digs(), 32'h223344FF);
        do_clear();

        // random messages, bubbles and random run pattern
        for (int t = 0; t < 3; t++) begin
            rand_tx($urandom_range(2, 16));
            load_tx(1);
            for (int i = 0; i < 60; i++) begin
                run = ($urandom_range(0, 3) != 0);
                cyc();
            end
            run = 1'b1;
            do_clear();
        end

        // clear together with an accepted in_last beat
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
        cyc();
        in_data = 8'hBB; in_last = 1'b1; clear = 1'b1;
        cyc();
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("clrlast_busy", {31'b0, busy}, 32'd0);
        chk("clrlast_ready", {31'b0, in_ready}, 32'd1);
        runc(3);
        chk("clrlast_blank", digs(), BLANK4);
        tx = '{8'h5A, 8'hA5, 8'h3C};
        load_tx(0);
        cyc();
        chk("fresh_w0", digs(), 32'h5AA53CFF);
        do_clear();

`ifdef SSEG_SCROLL_ONESHOT_EN
        // one-shot pass: done once, 24 cycles after SCROLL entry
        tx = '{8'hAA, 8'h55};
        load_tx(0);
        dn = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (done) dn++;
            if (k == 24) chk("os_done_at24", {31'b0, done}, 32'd1);
        end
        chk("os_done_count", dn, 32'd1);
        chk("os_busy", {31'b0, busy}, 32'd0);
        chk("os_blank", digs(), BLANK4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
